// File: rtl/nios_system_pushbutton_debounce.sv
// nios_system_pushbutton_debounce: per-channel two-flop synchronizer and counter debouncer for pushbutton pins
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   raw_in       raw asynchronous button pins
//   db_out       registered debounced levels
//   change_pulse one-cycle pulse with each db_out transition (only with PB_DEBOUNCE_PULSE_EN)
module nios_system_pushbutton_debounce #(
  parameter int WIDTH = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out
`ifdef PB_DEBOUNCE_PULSE_EN
  ,
  output logic [WIDTH-1:0] change_pulse
`endif
);
  localparam int CNT_W = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] s1, s2, diff, upd;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;
  // upd marks channels whose new level has persisted for the full window
  always_comb begin
    diff = s2 ^ db_out;
    upd = '0;
    for (int k = 0; k < WIDTH; k++) upd[k] = diff[k] && cnt[k] == CMAX;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      db_out <= RESET_VAL;
      cnt <= '0;
`ifdef PB_DEBOUNCE_PULSE_EN
      change_pulse <= '0;
`endif
    end else begin
      s1 <= raw_in;
      s2 <= s1;
      db_out <= db_out ^ upd;
      for (int k = 0; k < WIDTH; k++) cnt[k] <= (diff[k] && !upd[k]) ? cnt[k] + 1'b1 : '0;
`ifdef PB_DEBOUNCE_PULSE_EN
      change_pulse <= upd;
`endif
    end
endmodule

// File: tb/tb_nios_system_pushbutton_debounce.sv
// tb_nios_system_pushbutton_debounce: directed bench with a sliding-window model of the debouncer
module tb_nios_system_pushbutton_debounce;
  localparam int NC = 4;
  localparam logic [3:0] RV = 4'hF;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] raw_in = 4'h0;
  logic [3:0] db_out;
  logic [3:0] pulse;
  int checks = 0;
  int errors = 0;
  nios_system_pushbutton_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(NC), .RESET_VAL(RV)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_in(raw_in),
`ifdef PB_DEBOUNCE_PULSE_EN
    .change_pulse(pulse),
`endif
    .db_out(db_out)
  );
`ifndef PB_DEBOUNCE_PULSE_EN
  assign pulse = 4'h0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [3:0] a, input logic [3:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic chk_pulse(input string nm, input logic [3:0] e);
`ifdef PB_DEBOUNCE_PULSE_EN
    chk(nm, pulse, e);
`else
    if (e === 4'hx) chk(nm, pulse, e);
`endif
  endtask
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #3;
  endtask
  // Model: a bit flips at edge n when the synced level (raw sampled two edges
  // earlier) differed from the debounced level on each of the last NC edges,
  // none of which precede that bit's previous flip.
  logic [3:0] hist [0:4095];
  logic [3:0] m_db, m_pulse;
  int n;
  int last [4];
  function automatic logic [3:0] syn(input int k);
    return k >= 2 ? hist[k-2] : RV;
  endfunction
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        n = 0;
        m_db = RV;
        m_pulse = 4'h0;
        for (int i = 0; i < 4; i++) last[i] = -1;
      end else begin
        hist[n] = raw_in;
        m_pulse = 4'h0;
        for (int i = 0; i < 4; i++)
          if (n >= NC - 1 && last[i] <= n - NC) begin
            logic ok;
            ok = 1'b1;
            for (int k = n - NC + 1; k <= n; k++) if (syn(k)[i] == m_db[i]) ok = 1'b0;
            if (ok) begin
              m_db[i] = ~m_db[i];
              m_pulse[i] = 1'b1;
              last[i] = n;
            end
          end
        n++;
      end
      chk("model_db", db_out, m_db);
`ifdef PB_DEBOUNCE_PULSE_EN
      chk("model_pulse", pulse, m_pulse);
`endif
    end
  end
  initial begin
    step(4);
    chk("t1_reset_db", db_out, 4'hF);
    chk_pulse("t1_reset_pulse", 4'h0);
    @(negedge clk);
    raw_in = 4'hF;
    reset_n = 1'b1;
    step(8);
    chk("t1_idle_db", db_out, 4'hF);
    chk_pulse("t1_idle_pulse", 4'h0);
    @(negedge clk);
    raw_in = 4'hE;
    step(5);
    chk("t2_edge5_db", db_out, 4'hF);
    step(1);
    chk("t2_edge6_db", db_out, 4'hE);
    chk_pulse("t2_edge6_pulse", 4'h1);
    step(1);
    chk_pulse("t2_edge7_pulse", 4'h0);
    @(negedge clk);
    raw_in = 4'hC;
    repeat (3) @(negedge clk);
    raw_in = 4'hE;
    @(negedge clk);
    raw_in = 4'hC;
    step(5);
    chk("t3_edge5_db", db_out, 4'hE);
    step(1);
    chk("t3_edge6_db", db_out, 4'hC);
    chk_pulse("t3_edge6_pulse", 4'h2);
    @(negedge clk);
    raw_in = 4'h0;
    step(2);
    @(negedge clk);
    raw_in = 4'h1;
    step(4);
    chk("t4_pair_db", db_out, 4'h0);
    chk_pulse("t4_pair_pulse", 4'hC);
    step(1);
    chk("t4_gap_db", db_out, 4'h0);
    chk_pulse("t4_gap_pulse", 4'h0);
    step(1);
    chk("t4_bit0_db", db_out, 4'h1);
    chk_pulse("t4_bit0_pulse", 4'h1);
    @(negedge clk);
    raw_in = 4'h5;
    step(4);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t5_async_db", db_out, 4'hF);
    chk_pulse("t5_async_pulse", 4'h0);
    step(3);
    @(negedge clk);
    reset_n = 1'b1;
    step(5);
    chk("t5_edge5_db", db_out, 4'hF);
    step(1);
    chk("t5_edge6_db", db_out, 4'h5);
    chk_pulse("t5_edge6_pulse", 4'hA);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      raw_in = (c % 3 == 0) ? 4'hA : 4'h5;
    end
    @(negedge clk);
    raw_in = 4'h5;
    step(8);
    chk("t6_glitch_db", db_out, 4'h5);
    chk_pulse("t6_glitch_pulse", 4'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
